tile_serializer: RTL

Unload-side counterpart of the column-output transpose stage: accepts one full DIM_p-element column vector per handshake, buffers a complete DIM_p x DIM_p tile, then drains it as single (or paired) addressed elements. Sits between the systolic array's column outputs and the element-wide result path, and optionally transposes the tile on drain so results leave in row-major order.

---
 rtl/tile_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tile_serializer.sv
// Buffers one DIM_p x DIM_p tile of column vectors, then drains it as
// addressed single or paired elements, optionally transposed to row-major.
module tile_serializer #(
   parameter int DIM_p = 8,
   parameter int WIDTH_p = 8,
   parameter int double_output_p = 0,
   localparam int E_lp = (double_output_p != 0) ? 2 : 1,
   localparam int AW_lp = $clog2(DIM_p)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic                      transpose_i,
   input  logic [WIDTH_p-1:0]        col_data_i [DIM_p-1:0],
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [WIDTH_p*E_lp-1:0]   data_o,
   output logic [AW_lp-1:0]          row_o,
   output logic [AW_lp-1:0]          col_o,
   output logic                      last_o
);

   localparam int KW_lp = 2 * AW_lp;

   typedef enum logic {LOAD, DRAIN} state_e;

   state_e             state_q;
   logic [AW_lp-1:0]   load_cnt_q;
   logic [KW_lp-1:0]   k_q;
   logic               mode_q;
   logic               valid_q;
   logic               ready_q;

   logic [WIDTH_p-1:0] buf_q [DIM_p][DIM_p];

   logic               accept_w;
   logic               last_w;
   logic [AW_lp-1:0]   hi_w;
   logic [AW_lp-1:0]   lo_w;
   logic [AW_lp-1:0]   row_w;
   logic [AW_lp-1:0]   col_w;
   logic [WIDTH_p*E_lp-1:0] data_w;

   assign accept_w = valid_i && ready_q;
   assign last_w   = (k_q == KW_lp'(DIM_p * DIM_p - E_lp));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= LOAD;
         load_cnt_q <= '0;
         k_q        <= '0;
         mode_q     <= 1'b0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (accept_w) begin
                  if (load_cnt_q == '0)
                     mode_q <= transpose_i;
                  if (load_cnt_q == AW_lp'(DIM_p - 1)) begin
                     load_cnt_q <= '0;
                     state_q    <= DRAIN;
                     valid_q    <= 1'b1;
                     ready_q    <= 1'b0;
                  end else begin
                     load_cnt_q <= load_cnt_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (ready_i) begin
                  if (last_w) begin
                     k_q     <= '0;
                     state_q <= LOAD;
                     valid_q <= 1'b0;
                     ready_q <= 1'b1;
                  end else begin
                     k_q <= k_q + KW_lp'(E_lp);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   // Storage is deliberately left out of reset; a fresh load overwrites it.
   always_ff @(posedge clk_i) begin
      if (accept_w && state_q == LOAD && !rst_i) begin
         for (int r = 0; r < DIM_p; r++)
            buf_q[load_cnt_q][r] <= col_data_i[r];
      end
   end

   assign hi_w  = k_q[KW_lp-1:AW_lp];
   assign lo_w  = k_q[AW_lp-1:0];
   assign row_w = mode_q ? hi_w : lo_w;
   assign col_w = mode_q ? lo_w : hi_w;

   generate
      if (E_lp == 2) begin : g_pair
         logic [AW_lp-1:0] row_hi_w;
         logic [AW_lp-1:0] col_hi_w;
         // k is even, so the partner element never crosses a line.
         assign col_hi_w = col_w + AW_lp'(mode_q);
         assign row_hi_w = row_w + AW_lp'(!mode_q);
         assign data_w = {buf_q[col_hi_w][row_hi_w],
                          buf_q[col_w][row_w]};
      end else begin : g_single
         assign data_w = buf_q[col_w][row_w];
      end
   endgenerate

   assign valid_o = valid_q;
   assign ready_o = ready_q;

   always_comb begin
      data_o = '0;
      row_o  = '0;
      col_o  = '0;
      last_o = 1'b0;
      if (valid_q) begin
         data_o = data_w;
         row_o  = row_w;
         col_o  = col_w;
         last_o = last_w;
      end
   end

endmodule
